// File: rtl/ch_lru_sched_pkg.sv
// Shared types and sizes for the channel LRU scheduler slice.
package ch_lru_pkg;

   localparam int NCH  = 4;
   localparam int CH_W = 2;
   localparam int ID_W = 4;
   localparam int NID  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_e;

   // One-hot decode of a request ID into the busy-bitmap space.
   function automatic logic [NID-1:0] id_onehot(input logic [ID_W-1:0] id);
      logic [NID-1:0] one;
      one = {{(NID-1){1'b0}}, 1'b1};
      return one << id;
   endfunction

endpackage

// File: rtl/ch_lru_sched_if.sv
// Queue-side arbitration bus and downstream issue bus of the scheduler.
interface ch_lru_sched_if;
   import ch_lru_pkg::*;

   logic [NCH-1:0]  q_lru_join_ch;
   logic            q_sel_val;
   logic [ID_W-1:0] q_sel_req_id;
   logic            q_pe;
   logic            arb_val;
   logic [CH_W-1:0] arb_ch;
   logic [NID-1:0]  req_id_enb;
   logic            dn_rdy;
   logic            dn_val;
   logic [CH_W-1:0] dn_ch;
   logic [ID_W-1:0] dn_id;

   // Scheduler side.
   modport master (
      input  q_lru_join_ch, q_sel_val, q_sel_req_id, q_pe, dn_rdy,
      output arb_val, arb_ch, req_id_enb, dn_val, dn_ch, dn_id
   );

   // Queue / downstream side.
   modport slave (
      output q_lru_join_ch, q_sel_val, q_sel_req_id, q_pe, dn_rdy,
      input  arb_val, arb_ch, req_id_enb, dn_val, dn_ch, dn_id
   );

endinterface

// File: rtl/ch_lru_sched_lru4.sv
// Least-recently-granted channel order: priority pick plus move-to-MRU update.
// Slot 0 is LRU, slot NCH-1 is MRU. With no join bit set, pick_ch_o is slot 0.
module lru4_order
   import ch_lru_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NCH-1:0]  join_i,
   input  logic            upd_val_i,
   input  logic [CH_W-1:0] upd_ch_i,
   output logic [CH_W-1:0] pick_ch_o,
   output logic            pick_val_o
);

   logic [CH_W-1:0] order_q [NCH];
   logic [CH_W-1:0] order_d [NCH];
   logic [CH_W-1:0] pos_s;

   // Priority pick: the lowest slot whose channel has a joined entry wins.
   always_comb begin
      pick_ch_o  = order_q[0];
      pick_val_o = |join_i;
      for (int k = NCH - 1; k >= 0; k--) begin
         pick_ch_o = join_i[order_q[k]] ? order_q[k] : pick_ch_o;
      end
   end

   // Locate the slot currently holding the granted channel.
   always_comb begin
      pos_s = 2'd0;
      for (int k = 0; k < NCH; k++) begin
         pos_s = (order_q[k] == upd_ch_i) ? CH_W'(k) : pos_s;
      end
   end

   // Move the granted channel to MRU; slots behind it shift one toward LRU.
   always_comb begin
      for (int k = 0; k < NCH - 1; k++) begin
         order_d[k] = (upd_val_i && (CH_W'(k) >= pos_s)) ? order_q[k+1] : order_q[k];
      end
      order_d[NCH-1] = upd_val_i ? upd_ch_i : order_q[NCH-1];
   end

   // Order register; reset leaves channel k in slot k.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NCH; k++) begin
            order_q[k] <= CH_W'(k);
         end
      end else begin
         order_q <= order_d;
      end
   end

endmodule

// File: rtl/ch_lru_sched.sv
// Channel scheduler and ID-credit controller for the 16-entry request queue.
// Picks a channel in least-recently-granted order, tracks busy IDs until
// their completion returns, forwards grants downstream, and halts on parity.
module ch_lru_sched
   import ch_lru_pkg::*;
#(
   parameter int MAX_OUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en_i,
   input  logic [NID-1:0]  cfg_id_mask_i,
   input  logic            cmp_val_i,
   input  logic [ID_W-1:0] cmp_id_i,
   input  logic            err_clr_i,
   ch_lru_sched_if.master  bus,
   output logic [4:0]      outstanding_o,
   output logic            err_pe_o,
   output logic            err_cmp_o
);

   state_e          state_q, state_d;
   logic [NID-1:0]  busy_q, busy_d;
   logic [NID-1:0]  mask_q;
   logic [4:0]      out_q, out_d;
   logic            dn_val_q, dn_val_d;
   logic [CH_W-1:0] dn_ch_q, dn_ch_d;
   logic [ID_W-1:0] dn_id_q, dn_id_d;
   logic            err_pe_q, err_pe_d;
   logic            err_cmp_q, err_cmp_d;

   logic            arb_gate_s;
   logic [NCH-1:0]  join_s;
   logic [CH_W-1:0] pick_ch_s;
   logic            pick_val_s;
   logic            grant_s;
   logic            cmp_ok_s;
   logic            cmp_bad_s;

   // Arbitration is only offered in RUN with downstream room and free credit.
   // Masking the join vector makes the picker fall back to the LRU slot.
   assign arb_gate_s = (state_q == RUN) & bus.dn_rdy & (out_q < 5'(MAX_OUT));
   assign join_s     = arb_gate_s ? bus.q_lru_join_ch : {NCH{1'b0}};
   assign grant_s    = bus.q_sel_val & pick_val_s;
   assign cmp_ok_s   = cmp_val_i & busy_q[cmp_id_i];
   assign cmp_bad_s  = cmp_val_i & ~busy_q[cmp_id_i];

   lru4_order u_lru (
      .clk        (clk),
      .rst        (rst),
      .join_i     (join_s),
      .upd_val_i  (grant_s),
      .upd_ch_i   (pick_ch_s),
      .pick_ch_o  (pick_ch_s),
      .pick_val_o (pick_val_s)
   );

   assign bus.arb_val    = pick_val_s;
   assign bus.arb_ch     = pick_ch_s;
   assign bus.req_id_enb = ~busy_q & mask_q;
   assign bus.dn_val     = dn_val_q;
   assign bus.dn_ch      = dn_ch_q;
   assign bus.dn_id      = dn_id_q;
   assign outstanding_o  = out_q;
   assign err_pe_o       = err_pe_q;
   assign err_cmp_o      = err_cmp_q;

   // FSM next state; a parity error overrides every other transition.
   always_comb begin
      state_d = state_q;
      if (bus.q_pe) begin
         state_d = ERR;
      end else begin
         case (state_q)
            IDLE:    state_d = en_i ? RUN : IDLE;
            RUN:     state_d = en_i ? RUN : IDLE;
            ERR:     state_d = err_clr_i ? IDLE : ERR;
            default: state_d = IDLE;
         endcase
      end
   end

   // Credit tracking, issue capture and sticky error flags.
   // Completion is judged on pre-cycle busy, so a same-ID grant is spurious.
   always_comb begin
      busy_d    = (busy_q & ~(cmp_ok_s ? id_onehot(cmp_id_i) : {NID{1'b0}}))
                | (grant_s ? id_onehot(bus.q_sel_req_id) : {NID{1'b0}});
      out_d     = out_q + {4'b0000, grant_s} - {4'b0000, cmp_ok_s};
      dn_val_d  = grant_s;
      dn_ch_d   = grant_s ? pick_ch_s : dn_ch_q;
      dn_id_d   = grant_s ? bus.q_sel_req_id : dn_id_q;
      err_pe_d  = bus.q_pe ? 1'b1 : (err_clr_i ? 1'b0 : err_pe_q);
      err_cmp_d = cmp_bad_s ? 1'b1 : (err_clr_i ? 1'b0 : err_cmp_q);
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         busy_q    <= {NID{1'b0}};
         mask_q    <= {NID{1'b0}};
         out_q     <= 5'd0;
         dn_val_q  <= 1'b0;
         dn_ch_q   <= {CH_W{1'b0}};
         dn_id_q   <= {ID_W{1'b0}};
         err_pe_q  <= 1'b0;
         err_cmp_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         mask_q    <= cfg_id_mask_i;
         out_q     <= out_d;
         dn_val_q  <= dn_val_d;
         dn_ch_q   <= dn_ch_d;
         dn_id_q   <= dn_id_d;
         err_pe_q  <= err_pe_d;
         err_cmp_q <= err_cmp_d;
      end
   end

endmodule

// File: tb/tb_ch_lru_sched.sv
// Self-checking bench for ch_lru_sched: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_ch_lru_sched;
   import ch_lru_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en_r = 1'b0;
   logic [15:0] mask_r = 16'h0000;
   logic        cmp_r = 1'b0;
   logic [3:0]  cid_r = 4'd0;
   logic        clr_r = 1'b0;
   logic [3:0]  join_r = 4'd0;
   logic        sel_r = 1'b0;
   logic [3:0]  sid_r = 4'd0;
   logic        pe_r = 1'b0;
   logic        rdy_r = 1'b0;

   logic [4:0]  out1, out2;
   logic        epe1, ecmp1, epe2, ecmp2;

   int n_chk  = 0;
   int n_fail = 0;

   ch_lru_sched_if qif ();
   ch_lru_sched_if qif2 ();

   assign qif.q_lru_join_ch  = join_r;
   assign qif.q_sel_val      = sel_r;
   assign qif.q_sel_req_id   = sid_r;
   assign qif.q_pe           = pe_r;
   assign qif.dn_rdy         = rdy_r;
   assign qif2.q_lru_join_ch = join_r;
   assign qif2.q_sel_val     = sel_r;
   assign qif2.q_sel_req_id  = sid_r;
   assign qif2.q_pe          = pe_r;
   assign qif2.dn_rdy        = rdy_r;

   ch_lru_sched #(.MAX_OUT(16)) u_dut (
      .clk(clk), .rst(rst), .en_i(en_r), .cfg_id_mask_i(mask_r),
      .cmp_val_i(cmp_r), .cmp_id_i(cid_r), .err_clr_i(clr_r),
      .bus(qif.master), .outstanding_o(out1), .err_pe_o(epe1), .err_cmp_o(ecmp1)
   );

   ch_lru_sched #(.MAX_OUT(2)) u_dut2 (
      .clk(clk), .rst(rst), .en_i(en_r), .cfg_id_mask_i(mask_r),
      .cmp_val_i(cmp_r), .cmp_id_i(cid_r), .err_clr_i(clr_r),
      .bus(qif2.master), .outstanding_o(out2), .err_pe_o(epe2), .err_cmp_o(ecmp2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic idle_inputs();
      en_r = 1'b0; cmp_r = 1'b0; cid_r = 4'd0; clr_r = 1'b0;
      join_r = 4'd0; sel_r = 1'b0; sid_r = 4'd0; pe_r = 1'b0; rdy_r = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      mask_r = 16'h0000;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Load mask, enable and downstream ready; one edge moves IDLE to RUN.
   task automatic setup_run();
      mask_r = 16'hFFFF; en_r = 1'b1; rdy_r = 1'b1;
      @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_arb_val"}, 32'(qif.arb_val), 32'd0);
      chk({tag, "_arb_ch"}, 32'(qif.arb_ch), 32'd0);
      chk({tag, "_req_id_enb"}, 32'(qif.req_id_enb), 32'd0);
      chk({tag, "_dn_val"}, 32'(qif.dn_val), 32'd0);
      chk({tag, "_dn_ch"}, 32'(qif.dn_ch), 32'd0);
      chk({tag, "_dn_id"}, 32'(qif.dn_id), 32'd0);
      chk({tag, "_outstanding"}, 32'(out1), 32'd0);
      chk({tag, "_err_pe"}, 32'(epe1), 32'd0);
      chk({tag, "_err_cmp"}, 32'(ecmp1), 32'd0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        en;
      logic [3:0]  jn;
      logic        sel;
      logic [3:0]  sid;
      logic        cmp;
      logic [3:0]  cid;
      logic        av;
      logic [1:0]  ach;
      logic [4:0]  outs;
      logic        dv;
      logic [1:0]  dch;
      logic [3:0]  did;
      logic [15:0] enb;
      logic        ecmp;
   } vec_t;

   vec_t tbl [10];

   // ---------------- behavioural reference model ----------------
   state_e      m_st;
   logic [15:0] m_mask;
   logic [15:0] m_busy;
   int          m_ord[$];
   int          m_out;
   logic        m_dv;
   int          m_dch;
   int          m_did;
   logic        m_epe;
   logic        m_ecmp;

   task automatic model_init();
      m_st = IDLE; m_mask = 16'h0000; m_busy = 16'h0000;
      m_ord = '{0, 1, 2, 3};
      m_out = 0; m_dv = 1'b0; m_dch = 0; m_did = 0; m_epe = 1'b0; m_ecmp = 1'b0;
   endtask

   task automatic rand_step();
      logic av;
      int   ach;
      int   aidx;
      int   cand[$];
      int   bl[$];
      logic grant;
      logic cok;
      logic cbad;

      en_r  = ($urandom_range(99) < 95);
      rdy_r = ($urandom_range(99) < 85);
      join_r = 4'($urandom_range(15));
      pe_r  = ($urandom_range(199) == 0);
      clr_r = ($urandom_range(99) < 5);
      if ($urandom_range(99) < 5) begin
         mask_r = ($urandom_range(1) == 1) ? 16'hFFFF : 16'($urandom);
      end

      av = (m_st == RUN) && rdy_r && (m_out < 16) && (join_r != 4'd0);
      ach = m_ord[0];
      aidx = 0;
      if (av) begin
         for (int i = 0; i < m_ord.size(); i++) begin
            if (join_r[m_ord[i]]) begin
               ach = m_ord[i];
               aidx = i;
               break;
            end
         end
      end

      for (int i = 0; i < 16; i++) begin
         if (m_mask[i] && !m_busy[i]) cand.push_back(i);
         if (m_busy[i]) bl.push_back(i);
      end

      if (av && cand.size() > 0 && $urandom_range(99) < 85) begin
         sel_r = 1'b1;
         sid_r = 4'(cand[$urandom_range(cand.size() - 1)]);
      end else if (!av && $urandom_range(99) < 10) begin
         sel_r = 1'b1;
         sid_r = 4'($urandom_range(15));
      end else begin
         sel_r = 1'b0;
         sid_r = 4'($urandom_range(15));
      end

      if (bl.size() > 0 && $urandom_range(99) < 30) begin
         cmp_r = 1'b1;
         cid_r = 4'(bl[$urandom_range(bl.size() - 1)]);
      end else if ($urandom_range(99) < 3) begin
         cmp_r = 1'b1;
         cid_r = 4'($urandom_range(15));
      end else begin
         cmp_r = 1'b0;
         cid_r = 4'($urandom_range(15));
      end

      #1;
      chk("rnd_arb_val", 32'(qif.arb_val), 32'(av));
      chk("rnd_arb_ch", 32'(qif.arb_ch), 32'(ach));
      chk("rnd_req_id_enb", 32'(qif.req_id_enb), 32'(~m_busy & m_mask));
      chk("rnd_dn_val", 32'(qif.dn_val), 32'(m_dv));
      chk("rnd_dn_ch", 32'(qif.dn_ch), 32'(m_dch));
      chk("rnd_dn_id", 32'(qif.dn_id), 32'(m_did));
      chk("rnd_outstanding", 32'(out1), 32'(m_out));
      chk("rnd_err_pe", 32'(epe1), 32'(m_epe));
      chk("rnd_err_cmp", 32'(ecmp1), 32'(m_ecmp));

      grant = sel_r && av;
      cok   = cmp_r && m_busy[cid_r];
      cbad  = cmp_r && !m_busy[cid_r];

      if (pe_r) m_st = ERR;
      else if (m_st == ERR) m_st = clr_r ? IDLE : ERR;
      else m_st = en_r ? RUN : IDLE;

      if (pe_r) m_epe = 1'b1;
      else if (clr_r) m_epe = 1'b0;
      if (cbad) m_ecmp = 1'b1;
      else if (clr_r) m_ecmp = 1'b0;

      if (cok) begin
         m_busy[cid_r] = 1'b0;
         m_out = m_out - 1;
      end
      if (grant) begin
         m_busy[sid_r] = 1'b1;
         m_out = m_out + 1;
         m_ord.delete(aidx);
         m_ord.push_back(ach);
         m_dch = ach;
         m_did = int'(sid_r);
      end
      m_dv = grant;
      m_mask = mask_r;

      @(negedge clk);
   endtask

   initial begin
      tbl[0] = '{1'b1, 4'hF, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 2'd0, 5'd0, 1'b0, 2'd0, 4'd0, 16'hFFFF, 1'b0};
      tbl[1] = '{1'b1, 4'hF, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 2'd1, 5'd1, 1'b1, 2'd0, 4'd0, 16'hFFFE, 1'b0};
      tbl[2] = '{1'b1, 4'hF, 1'b1, 4'd2, 1'b0, 4'd0, 1'b1, 2'd2, 5'd2, 1'b1, 2'd1, 4'd1, 16'hFFFC, 1'b0};
      tbl[3] = '{1'b1, 4'hF, 1'b1, 4'd3, 1'b0, 4'd0, 1'b1, 2'd3, 5'd3, 1'b1, 2'd2, 4'd2, 16'hFFF8, 1'b0};
      tbl[4] = '{1'b1, 4'hF, 1'b1, 4'd4, 1'b0, 4'd0, 1'b1, 2'd0, 5'd4, 1'b1, 2'd3, 4'd3, 16'hFFF0, 1'b0};
      tbl[5] = '{1'b1, 4'h5, 1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 2'd2, 5'd5, 1'b1, 2'd0, 4'd4, 16'hFFE0, 1'b0};
      tbl[6] = '{1'b1, 4'h5, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 2'd0, 5'd6, 1'b1, 2'd2, 4'd5, 16'hFFC0, 1'b0};
      tbl[7] = '{1'b1, 4'h0, 1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 2'd1, 5'd6, 1'b0, 2'd2, 4'd5, 16'hFFC0, 1'b0};
      tbl[8] = '{1'b1, 4'h0, 1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 2'd1, 5'd5, 1'b0, 2'd2, 4'd5, 16'hFFC1, 1'b0};
      tbl[9] = '{1'b1, 4'h0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 2'd1, 5'd5, 1'b0, 2'd2, 4'd5, 16'hFFC1, 1'b1};

      // Reset state.
      do_reset();
      #1;
      chk_reset_outputs("reset");
      @(negedge clk);

      // Vector table: LRU rotation, single grant issue, completion, spurious completion.
      do_reset();
      setup_run();
      for (int i = 0; i < 10; i++) begin
         en_r = tbl[i].en; join_r = tbl[i].jn; sel_r = tbl[i].sel; sid_r = tbl[i].sid;
         cmp_r = tbl[i].cmp; cid_r = tbl[i].cid;
         #1;
         chk($sformatf("vec%0d_arb_val", i), 32'(qif.arb_val), 32'(tbl[i].av));
         chk($sformatf("vec%0d_arb_ch", i), 32'(qif.arb_ch), 32'(tbl[i].ach));
         chk($sformatf("vec%0d_outstanding", i), 32'(out1), 32'(tbl[i].outs));
         chk($sformatf("vec%0d_dn_val", i), 32'(qif.dn_val), 32'(tbl[i].dv));
         chk($sformatf("vec%0d_dn_ch", i), 32'(qif.dn_ch), 32'(tbl[i].dch));
         chk($sformatf("vec%0d_dn_id", i), 32'(qif.dn_id), 32'(tbl[i].did));
         chk($sformatf("vec%0d_req_id_enb", i), 32'(qif.req_id_enb), 32'(tbl[i].enb));
         chk($sformatf("vec%0d_err_cmp", i), 32'(ecmp1), 32'(tbl[i].ecmp));
         @(negedge clk);
      end

      // Same-cycle grant and completion of ID 3: completion is spurious.
      do_reset();
      setup_run();
      join_r = 4'b0001; sel_r = 1'b1; sid_r = 4'd3; cmp_r = 1'b1; cid_r = 4'd3;
      #1;
      chk("same_arb_val", 32'(qif.arb_val), 32'd1);
      @(negedge clk);
      sel_r = 1'b0; cmp_r = 1'b0;
      #1;
      chk("same_err_cmp", 32'(ecmp1), 32'd1);
      chk("same_enb3", 32'(qif.req_id_enb[3]), 32'd0);
      chk("same_outstanding", 32'(out1), 32'd1);

      // Parity halt during RUN, then recovery through IDLE.
      @(negedge clk);
      pe_r = 1'b1;
      @(negedge clk);
      pe_r = 1'b0;
      #1;
      chk("pe_arb_val", 32'(qif.arb_val), 32'd0);
      chk("pe_err_pe", 32'(epe1), 32'd1);
      @(negedge clk);
      #1;
      chk("pe_hold_arb_val", 32'(qif.arb_val), 32'd0);
      clr_r = 1'b1;
      @(negedge clk);
      clr_r = 1'b0;
      #1;
      chk("clr_idle_arb_val", 32'(qif.arb_val), 32'd0);
      chk("clr_err_pe", 32'(epe1), 32'd0);
      chk("clr_err_cmp", 32'(ecmp1), 32'd0);
      @(negedge clk);
      #1;
      chk("clr_run_arb_val", 32'(qif.arb_val), 32'd1);
      @(negedge clk);

      // Credit limit on the MAX_OUT=2 instance.
      do_reset();
      setup_run();
      join_r = 4'b0001; sel_r = 1'b1; sid_r = 4'd7;
      #1;
      chk("cred_g1_arb_val", 32'(qif2.arb_val), 32'd1);
      @(negedge clk);
      sid_r = 4'd8;
      #1;
      chk("cred_g2_arb_val", 32'(qif2.arb_val), 32'd1);
      @(negedge clk);
      sel_r = 1'b0;
      #1;
      chk("cred_full_arb_val", 32'(qif2.arb_val), 32'd0);
      chk("cred_full_outstanding", 32'(out2), 32'd2);
      cmp_r = 1'b1; cid_r = 4'd7;
      #1;
      chk("cred_cmp_same_arb_val", 32'(qif2.arb_val), 32'd0);
      @(negedge clk);
      cmp_r = 1'b0;
      #1;
      chk("cred_after_cmp_arb_val", 32'(qif2.arb_val), 32'd1);
      chk("cred_after_cmp_outstanding", 32'(out2), 32'd1);
      @(negedge clk);

      // Asynchronous reset with three IDs outstanding.
      do_reset();
      setup_run();
      join_r = 4'hF; sel_r = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         sid_r = 4'(i);
         @(negedge clk);
      end
      sel_r = 1'b0;
      #1;
      chk("arst_pre_outstanding", 32'(out1), 32'd3);
      #1;
      rst = 1'b0;
      #1;
      chk_reset_outputs("arst");
      @(negedge clk);
      rst = 1'b1;
      join_r = 4'd0;
      cmp_r = 1'b1; cid_r = 4'd1;
      @(negedge clk);
      cmp_r = 1'b0;
      #1;
      chk("arst_late_cmp_err", 32'(ecmp1), 32'd1);
      chk("arst_late_cmp_outstanding", 32'(out1), 32'd0);
      @(negedge clk);

      // Randomized traffic against the reference model.
      do_reset();
      mask_r = 16'hFFFF;
      model_init();
      for (int c = 0; c < 4000; c++) begin
         rand_step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
